// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the RV32I load/store unit.
// Holds the funct3 encodings, the FSM state type and the access-size decoder.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_NONE
  } lsu_size_t;

  function automatic lsu_size_t size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      F3_W:        return SZ_WORD;
      default:     return SZ_NONE;
    endcase
  endfunction

  // Stores have no unsigned variants, so funct3[2] is only legal on loads.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    return (size_of(funct3) != SZ_NONE) && !(we && funct3[2]);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, response and data-RAM signals of the load/store unit.
// The LSU takes the slave view; the execute stage and RAM together take the master view.
interface lsu_if #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
);

  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [2:0]            i_req_funct3;
  logic [ADDR_WIDTH:0]   i_req_addr;
  logic [DATA_WIDTH:0]   i_req_wdata;

  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH:0]   o_rsp_rdata;
  logic                  o_rsp_err;

  logic                  o_mem_read_req;
  logic [ADDR_WIDTH:0]   o_mem_addr;
  logic [DATA_WIDTH:0]   i_mem_read_data;
  logic                  o_mem_write_enable;
  logic [3:0]            o_mem_byte_enable;
  logic [DATA_WIDTH:0]   o_mem_write_data;

  modport slave (
    input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
    input  i_rsp_ready, i_mem_read_data,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_mem_read_req, o_mem_addr, o_mem_write_enable, o_mem_byte_enable,
    output o_mem_write_data
  );

  modport master (
    output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
    output i_rsp_ready, i_mem_read_data,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_mem_read_req, o_mem_addr, o_mem_write_enable, o_mem_byte_enable,
    input  o_mem_write_data
  );

endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a RAM word and sign- or zero-extends it.
// Purely combinational so the cache path can share it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 31
) (
  input  logic [DATA_WIDTH:0] word_data,
  input  logic [1:0]          byte_offset,
  input  logic [2:0]          funct3,
  output logic [DATA_WIDTH:0] load_data
);

  logic [DATA_WIDTH:0] shifted;

  always_comb begin
    shifted   = word_data >> {byte_offset, 3'b000};
    // NOTE: every output gets a value before the case so no path leaves it unassigned (no latch).
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{(DATA_WIDTH - 7){shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{(DATA_WIDTH - 15){shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {{(DATA_WIDTH - 7){1'b0}}, shifted[7:0]};
      F3_HU:   load_data = {{(DATA_WIDTH - 15){1'b0}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one byte-addressed access at a time, translated to word address,
// lane enables and replicated store data; loads wait out the RAM's registered read.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31,
  parameter int MEM_WORDS  = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clk_en,
  lsu_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] WORD_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

  lsu_state_t          state;
  logic                req_we;
  logic [2:0]          req_funct3;
  logic [1:0]          req_offset;

  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [DATA_WIDTH:0] rsp_rdata_q;
  logic                rsp_err_q;
  logic                mem_read_req_q;
  logic [ADDR_WIDTH:0] mem_addr_q;
  logic                mem_we_q;
  logic [3:0]          mem_be_q;
  logic [DATA_WIDTH:0] mem_wdata_q;

  lsu_size_t           req_size;
  logic [ADDR_WIDTH:0] word_addr;
  logic                misaligned;
  logic                out_of_range;
  logic                acc_err;
  logic [3:0]          store_be;
  logic [DATA_WIDTH:0] store_wdata;
  logic [DATA_WIDTH:0] load_data;

  // Decode of the request as presented; only consumed on the accept edge.
  always_comb begin
    req_size     = size_of(bus.i_req_funct3);
    word_addr    = {2'b00, bus.i_req_addr[ADDR_WIDTH:2]};
    misaligned   = ((req_size == SZ_HALF) && bus.i_req_addr[0]) ||
                   ((req_size == SZ_WORD) && (bus.i_req_addr[1:0] != 2'b00));
    out_of_range = word_addr >= WORD_LIMIT;
    acc_err      = !is_legal(bus.i_req_we, bus.i_req_funct3) || misaligned || out_of_range;

    store_be    = 4'b0000;
    store_wdata = '0;
    case (req_size)
      SZ_BYTE: begin
        store_be    = 4'b0001 << bus.i_req_addr[1:0];
        store_wdata = {4{bus.i_req_wdata[7:0]}};
      end
      SZ_HALF: begin
        store_be    = bus.i_req_addr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{bus.i_req_wdata[15:0]}};
      end
      SZ_WORD: begin
        store_be    = 4'b1111;
        store_wdata = bus.i_req_wdata;
      end
      default: ;
    endcase
  end

  lsu_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_align (
    .word_data   (bus.i_mem_read_data),
    .byte_offset (req_offset),
    .funct3      (req_funct3),
    .load_data   (load_data)
  );

  // ISSUE-cycle RAM outputs are loaded on the accept edge so they are visible
  // during ISSUE itself and cleared on the way out, giving single-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      req_we         <= 1'b0;
      req_funct3     <= F3_B;
      req_offset     <= 2'b00;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      mem_read_req_q <= 1'b0;
      mem_addr_q     <= '0;
      mem_we_q       <= 1'b0;
      mem_be_q       <= 4'b0000;
      mem_wdata_q    <= '0;
    end else if (i_clk_en) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (bus.i_req_valid && req_ready_q) begin
            req_we      <= bus.i_req_we;
            req_funct3  <= bus.i_req_funct3;
            req_offset  <= bus.i_req_addr[1:0];
            req_ready_q <= 1'b0;
            rsp_rdata_q <= '0;
            if (acc_err) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              state       <= RESP;
            end else begin
              rsp_err_q      <= 1'b0;
              mem_addr_q     <= word_addr;
              mem_we_q       <= bus.i_req_we;
              mem_read_req_q <= !bus.i_req_we;
              mem_be_q       <= bus.i_req_we ? store_be : 4'b0000;
              mem_wdata_q    <= bus.i_req_we ? store_wdata : '0;
              state          <= ISSUE;
            end
          end
        end

        ISSUE: begin
          mem_we_q       <= 1'b0;
          mem_read_req_q <= 1'b0;
          mem_be_q       <= 4'b0000;
          mem_wdata_q    <= '0;
          if (req_we) begin
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          rsp_rdata_q <= load_data;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end

        RESP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.o_req_ready        = req_ready_q;
  assign bus.o_rsp_valid        = rsp_valid_q;
  assign bus.o_rsp_rdata        = rsp_rdata_q;
  assign bus.o_rsp_err          = rsp_err_q;
  assign bus.o_mem_read_req     = mem_read_req_q;
  assign bus.o_mem_addr         = mem_addr_q;
  assign bus.o_mem_write_enable = mem_we_q;
  assign bus.o_mem_byte_enable  = mem_be_q;
  assign bus.o_mem_write_data   = mem_wdata_q;

endmodule
